// File: rtl/lane_pack_fifo_pkg.sv
// ---------------------------------------------------------------------------
// lane_pack_fifo_pkg
// Shared definitions for the narrow-to-wide store packing path: default
// element/word geometry, the packed entry layout handed to the VLSU write side,
// and a small index-width helper.
// ---------------------------------------------------------------------------
package lane_pack_fifo_pkg;

    localparam int PACK_IN_W   = 32;
    localparam int PACK_OUT_W  = 128;
    localparam int PACK_RATIO  = PACK_OUT_W / PACK_IN_W;
    localparam int PACK_DEPTH  = 4;

    // One committed wide word. Field order is the bit layout of entry_o from the
    // assembler: {data, strb, last}.
    typedef struct packed {
        logic [PACK_OUT_W-1:0] data;
        logic [PACK_RATIO-1:0] strb;
        logic                  last;
    } pack_entry_t;

    // Index width for a 0..n-1 counter; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lane_pack_fifo_assembler.sv
// ---------------------------------------------------------------------------
// lane_pack_assembler
// Gathers IN_DATA_WIDTH elements into one OUT_DATA_WIDTH word. The accepted
// element is merged combinationally so a word commits in the same cycle as
// its completing element (slot RATIO-1 filled, or last_i).
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   flush_i         drop the partial word, fill index back to 0
//   push_i          element accepted this cycle
//   data_i, last_i  element and transfer-end flag
//   commit_o        entry_o must be written to storage this cycle
//   entry_o         {data, strb, last} of the word being committed
// ---------------------------------------------------------------------------
module lane_pack_assembler
    import lane_pack_fifo_pkg::*;
#(
    parameter int IN_DATA_WIDTH  = PACK_IN_W,
    parameter int OUT_DATA_WIDTH = PACK_OUT_W,
    parameter int RATIO          = OUT_DATA_WIDTH / IN_DATA_WIDTH,
    parameter int ENTRY_W        = OUT_DATA_WIDTH + RATIO + 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [IN_DATA_WIDTH-1:0] data_i,
    input  logic                     last_i,
    output logic                     commit_o,
    output logic [ENTRY_W-1:0]       entry_o
);

    localparam int FILL_W = idx_width(RATIO);

    logic [OUT_DATA_WIDTH-1:0] r_data;
    logic [RATIO-1:0]          r_strb;
    logic [FILL_W-1:0]         r_fill;

    logic [OUT_DATA_WIDTH-1:0] w_data;
    logic [RATIO-1:0]          w_strb;
    logic                      w_slot_last;

    assign w_slot_last = (r_fill == FILL_W'(RATIO - 1));
    assign commit_o    = push_i & (w_slot_last | last_i);

    // Assembly register with the incoming element dropped into its slot.
    always_comb begin
        w_data = r_data;
        w_strb = r_strb;
        for (int k = 0; k < RATIO; k++) begin
            if (push_i && (r_fill == FILL_W'(k))) begin
                w_data[k*IN_DATA_WIDTH +: IN_DATA_WIDTH] = data_i;
                w_strb[k]                                 = 1'b1;
            end
        end
    end

    assign entry_o = {w_data, w_strb, last_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data <= '0;
            r_strb <= '0;
            r_fill <= '0;
        end else if (flush_i || commit_o) begin
            // Committed words leave the register clean so unfilled slots of
            // the next partial word read back as zero.
            r_data <= '0;
            r_strb <= '0;
            r_fill <= '0;
        end else if (push_i) begin
            r_data <= w_data;
            r_strb <= w_strb;
            r_fill <= r_fill + FILL_W'(1);
        end
    end

endmodule

// File: rtl/lane_pack_fifo.sv
// ---------------------------------------------------------------------------
// lane_pack_fifo
// Narrow-to-wide packing FIFO for the store path. Elements are packed into
// wide words by lane_pack_assembler; completed words land in a DEPTH-entry
// first-word-fall-through queue read by the VLSU write side.
// Ports:
//   clk_i, rst_ni, flush_i          clock, async active-low reset, sync clear
//   data_i, valid_i, last_i, ready_o  element push handshake
//   data_o, strb_o, last_o          head word, element mask, transfer end
//   valid_o, ready_i                head pop handshake
//   usage_o                         committed wide entries, 0..DEPTH
// ---------------------------------------------------------------------------
module lane_pack_fifo
    import lane_pack_fifo_pkg::*;
#(
    parameter int IN_DATA_WIDTH  = PACK_IN_W,
    parameter int OUT_DATA_WIDTH = PACK_OUT_W,
    parameter int DEPTH          = PACK_DEPTH,
    parameter int RATIO          = OUT_DATA_WIDTH / IN_DATA_WIDTH,
    parameter int ADDR_DEPTH     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic [IN_DATA_WIDTH-1:0]  data_i,
    input  logic                      valid_i,
    input  logic                      last_i,
    output logic                      ready_o,
    output logic [OUT_DATA_WIDTH-1:0] data_o,
    output logic [RATIO-1:0]          strb_o,
    output logic                      last_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [ADDR_DEPTH:0]       usage_o
);

    localparam int ENTRY_W = OUT_DATA_WIDTH + RATIO + 1;

    typedef struct packed {
        logic [OUT_DATA_WIDTH-1:0] data;
        logic [RATIO-1:0]          strb;
        logic                      last;
    } entry_t;

    entry_t                r_mem [DEPTH];
    logic [ADDR_DEPTH-1:0] r_wr_ptr;
    logic [ADDR_DEPTH-1:0] r_rd_ptr;
    logic [ADDR_DEPTH:0]   r_usage;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_commit;
    logic [ENTRY_W-1:0]    w_entry_bits;
    entry_t                w_entry;
    entry_t                w_head;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [ADDR_DEPTH-1:0] ptr_inc(input logic [ADDR_DEPTH-1:0] p);
        return (p == ADDR_DEPTH'(DEPTH - 1)) ? '0 : p + ADDR_DEPTH'(1);
    endfunction

    // ready_o depends on stored state only; it also holds off pushes that
    // would not commit, keeping the handshake free of combinational paths.
    assign ready_o = (r_usage != (ADDR_DEPTH+1)'(DEPTH));
    assign valid_o = (r_usage != '0);
    assign w_push  = valid_i & ready_o;
    assign w_pop   = valid_o & ready_i;

    lane_pack_assembler #(
        .IN_DATA_WIDTH  (IN_DATA_WIDTH),
        .OUT_DATA_WIDTH (OUT_DATA_WIDTH),
        .RATIO          (RATIO),
        .ENTRY_W        (ENTRY_W)
    ) u_asm (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .flush_i  (flush_i),
        .push_i   (w_push),
        .data_i   (data_i),
        .last_i   (last_i),
        .commit_o (w_commit),
        .entry_o  (w_entry_bits)
    );

    assign w_entry = w_entry_bits;
    assign w_head  = r_mem[r_rd_ptr];
    assign data_o  = w_head.data;
    assign strb_o  = w_head.strb;
    assign last_o  = w_head.last;
    assign usage_o = r_usage;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_usage  <= '0;
        end else if (flush_i) begin
            // Storage contents are left stale; empty pointers hide them.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_usage  <= '0;
        end else begin
            if (w_commit) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_commit, w_pop})
                2'b10:   r_usage <= r_usage + 1'b1;
                2'b01:   r_usage <= r_usage - 1'b1;
                default: r_usage <= r_usage;
            endcase
        end
    end

    // Geometry sanity at elaboration.
    if (RATIO * IN_DATA_WIDTH != OUT_DATA_WIDTH) begin : g_bad_ratio
        $error("lane_pack_fifo: OUT_DATA_WIDTH must be a multiple of IN_DATA_WIDTH");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("lane_pack_fifo: DEPTH must be at least 1");
    end

    a_no_empty_pop: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (!valid_o && ready_i) |-> !w_pop);

    a_stable_in: assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
        (valid_i && !ready_o) |=> ($stable(data_i) && $stable(last_i)));

endmodule

// File: tb/tb_lane_pack_fifo.sv
module tb_lane_pack_fifo;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b1;
    logic         flush_i = 1'b0;
    logic [31:0]  data_i = '0;
    logic         valid_i = 1'b0;
    logic         last_i = 1'b0;
    logic         ready_o;
    logic [127:0] data_o;
    logic [3:0]   strb_o;
    logic         last_o;
    logic         valid_o;
    logic         ready_i = 1'b1;
    logic [2:0]   usage_o;

    lane_pack_fifo #(
        .IN_DATA_WIDTH  (32),
        .OUT_DATA_WIDTH (128),
        .DEPTH          (4)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .last_i  (last_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .strb_o  (strb_o),
        .last_o  (last_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .usage_o (usage_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [127:0] d;
        logic [3:0]   s;
        logic         l;
    } exp_t;

    typedef struct {
        logic [3:0][31:0] e;
        int               n;
        bit               lst;
        logic [127:0]     exp_data;
        logic [3:0]       exp_strb;
        bit               exp_last;
    } vec_t;

    vec_t vecs [6];
    exp_t sbq [$];
    exp_t mon_x;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every word popped by the DUT must match the head.
    always @(negedge clk_i) begin
        if (rst_ni && valid_o && ready_i) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h want none", data_o);
            end else begin
                mon_x = sbq.pop_front();
                chk("word_data", data_o, mon_x.d);
                chk("word_strb", strb_o, mon_x.s);
                chk("word_last", last_o, mon_x.l);
            end
        end
    end

    // Hold the element until accepted; returns at posedge+1.
    task automatic push(input logic [31:0] d, input logic l);
        int   cyc;
        logic acc;
        cyc = 0;
        acc = 1'b0;
        valid_i = 1'b1;
        data_i  = d;
        last_i  = l;
        while (!acc) begin
            @(negedge clk_i);
            acc = ready_o;
            @(posedge clk_i);
            #1;
            cyc++;
            if (!acc && cyc > 200) begin
                checks++;
                errors++;
                $display("FAIL push_timeout: got stalled want accept");
                break;
            end
        end
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        ready_i = 1'b1;
        while (sbq.size() != 0 && cyc < 100) begin
            @(posedge clk_i);
            #1;
            cyc++;
        end
        chk("drain_left", sbq.size(), 0);
        chk("drain_usage", usage_o, 0);
    endtask

    task automatic cyc1();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{e: {32'h8, 32'h7, 32'h6, 32'h5}, n: 4, lst: 0,
                    exp_data: 128'h00000008_00000007_00000006_00000005, exp_strb: 4'hF, exp_last: 0};
        vecs[1] = '{e: {32'h8, 32'h7, 32'h6, 32'h5}, n: 4, lst: 0,
                    exp_data: 128'h00000008_00000007_00000006_00000005, exp_strb: 4'hF, exp_last: 0};
        vecs[2] = '{e: {32'h0, 32'h0, 32'hA, 32'h9}, n: 2, lst: 1,
                    exp_data: 128'h00000000_00000000_0000000A_00000009, exp_strb: 4'h3, exp_last: 1};
        vecs[3] = '{e: {32'h0, 32'h0, 32'h0, 32'hC}, n: 1, lst: 1,
                    exp_data: 128'h00000000_00000000_00000000_0000000C, exp_strb: 4'h1, exp_last: 1};
        vecs[4] = '{e: {32'h10, 32'hF, 32'hE, 32'hD}, n: 4, lst: 1,
                    exp_data: 128'h00000010_0000000F_0000000E_0000000D, exp_strb: 4'hF, exp_last: 1};
        vecs[5] = '{e: {32'h0, 32'h23, 32'h22, 32'h21}, n: 3, lst: 1,
                    exp_data: 128'h00000000_00000023_00000022_00000021, exp_strb: 4'h7, exp_last: 1};

        // Reset state
        #1 rst_ni = 1'b0;
        #12;
        chk("rst_ready", ready_o, 1);
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_strb", strb_o, 0);
        chk("rst_last", last_o, 0);
        chk("rst_usage", usage_o, 0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        cyc1();

        // First word: visible exactly one cycle after the 4th accept
        sbq.push_back('{d: 128'h00000004_00000003_00000002_00000001, s: 4'hF, l: 1'b0});
        push(32'h1, 0);
        push(32'h2, 0);
        push(32'h3, 0);
        chk("lat_before", valid_o, 0);
        push(32'h4, 0);
        chk("lat_after", valid_o, 1);

        // Table vectors
        for (int i = 0; i < 6; i++) begin
            sbq.push_back('{d: vecs[i].exp_data, s: vecs[i].exp_strb, l: vecs[i].exp_last});
            for (int k = 0; k < vecs[i].n; k++)
                push(vecs[i].e[k], vecs[i].lst && (k == vecs[i].n - 1));
        end
        drain();

        // Backpressure: fill all four entries
        ready_i = 1'b0;
        for (int w = 0; w < 4; w++) begin
            sbq.push_back('{d: {32'h103 + 32'(4*w), 32'h102 + 32'(4*w),
                                32'h101 + 32'(4*w), 32'h100 + 32'(4*w)}, s: 4'hF, l: 1'b0});
            for (int k = 0; k < 4; k++) push(32'h100 + 32'(4*w + k), 0);
        end
        chk("full_usage", usage_o, 4);
        chk("full_ready", ready_o, 0);
        valid_i = 1'b1;
        data_i  = 32'h200;
        last_i  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cyc1();
            chk("stall_ready", ready_o, 0);
            chk("stall_usage", usage_o, 4);
        end
        sbq.push_back('{d: 128'h00000203_00000202_00000201_00000200, s: 4'hF, l: 1'b0});
        ready_i = 1'b1;
        cyc1();
        ready_i = 1'b0;
        chk("pop_ready", ready_o, 1);
        chk("pop_usage", usage_o, 3);
        cyc1();
        valid_i = 1'b0;
        chk("acc17_usage", usage_o, 3);
        push(32'h201, 0);
        push(32'h202, 0);
        push(32'h203, 0);
        chk("refill_usage", usage_o, 4);

        // Commit and pop in the same cycle keep usage steady
        ready_i = 1'b1;
        cyc1();
        ready_i = 1'b0;
        chk("pre_coinc_usage", usage_o, 3);
        sbq.push_back('{d: 128'h00000303_00000302_00000301_00000300, s: 4'hF, l: 1'b1});
        push(32'h300, 0);
        push(32'h301, 0);
        push(32'h302, 0);
        ready_i = 1'b1;
        push(32'h303, 1);
        ready_i = 1'b0;
        chk("coinc_usage", usage_o, 3);
        drain();

        // Flush drops a partial word
        push(32'h11, 0);
        push(32'h22, 0);
        flush_i = 1'b1;
        cyc1();
        flush_i = 1'b0;
        chk("flush_usage", usage_o, 0);
        chk("flush_valid", valid_o, 0);
        chk("flush_ready", ready_o, 1);
        sbq.push_back('{d: 128'h00000004_00000003_00000002_00000001, s: 4'hF, l: 1'b0});
        for (int k = 1; k <= 4; k++) push(32'(k), 0);
        drain();

        // Flush also drops committed words
        ready_i = 1'b0;
        for (int k = 0; k < 4; k++) push(32'h60 + 32'(k), 0);
        chk("flush2_pre", usage_o, 1);
        flush_i = 1'b1;
        cyc1();
        flush_i = 1'b0;
        chk("flush2_usage", usage_o, 0);
        chk("flush2_valid", valid_o, 0);

        // Async reset mid-word with two entries held
        for (int k = 0; k < 8; k++) push(32'h400 + 32'(k), 0);
        push(32'h500, 0);
        push(32'h501, 0);
        chk("prerst_usage", usage_o, 2);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_valid", valid_o, 0);
        chk("arst_usage", usage_o, 0);
        chk("arst_ready", ready_o, 1);
        chk("arst_strb", strb_o, 0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        cyc1();
        sbq.push_back('{d: 128'h00000034_00000033_00000032_00000031, s: 4'hF, l: 1'b0});
        ready_i = 1'b1;
        for (int k = 1; k <= 4; k++) push(32'h30 + 32'(k), 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
